// File: rtl/maze_pkg.sv
// maze_pkg
// Shared definitions for the tile-maze game controller:
//   - 3-bit phase encodings (also driven out on the phase port)
//   - difficulty select codes
//   - bit positions of the move_req pulse vector
//   - sat_step(): one-tile step clamped to the map edge
package maze_pkg;

    // Game phases
    localparam logic [2:0] ST_MENU     = 3'd0;
    localparam logic [2:0] ST_SHOW_MAP = 3'd1;
    localparam logic [2:0] ST_PLAYING  = 3'd2;
    localparam logic [2:0] ST_CHECK    = 3'd3;
    localparam logic [2:0] ST_LOST     = 3'd4;
    localparam logic [2:0] ST_WON      = 3'd5;

    // Difficulty select codes; 2'b11 is handled as hard
    localparam logic [1:0] DIFF_EASY = 2'b00;
    localparam logic [1:0] DIFF_MED  = 2'b01;
    localparam logic [1:0] DIFF_HARD = 2'b10;

    // Bit indices into move_req
    localparam int DIR_UP    = 0;
    localparam int DIR_DOWN  = 1;
    localparam int DIR_LEFT  = 2;
    localparam int DIR_RIGHT = 3;

    // Step one tile up (inc=1) or down (inc=0), holding at 0 and max_pos
    function automatic logic [7:0] sat_step(input logic [7:0] pos,
                                            input logic       inc,
                                            input logic [7:0] max_pos);
        logic [7:0] res;
        if (inc) begin
            res = (pos >= max_pos) ? pos : pos + 8'd1;
        end else begin
            res = (pos == 8'd0) ? pos : pos - 8'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/move_cooldown.sv
// move_cooldown
// Loadable down-counter that stops at zero.
//   clk, reset : clock, synchronous active-high reset (count cleared)
//   load       : load load_val this cycle (wins over counting)
//   load_val   : value to load
//   zero       : count is currently zero
module move_cooldown #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/maze_game_ctrl.sv
// maze_game_ctrl
// Game controller for the tile-maze game: menu, timed map reveal, rate-limited
// movement with wall collision against an external synchronous map ROM, lives
// and win/lose.
//   clk, reset   : clock, synchronous active-high reset
//   start        : pulse; MENU -> game start, LOST/WON -> MENU
//   diff_sel     : difficulty, sampled on start in MENU
//   move_req     : pulses [0]=up [1]=down [2]=left [3]=right
//   rom_addr     : map row address (ROM returns the row one cycle later)
//   rom_data     : map row, bit x set = wall at column x
//   player_x/y   : player tile position
//   lives_left   : remaining lives
//   phase        : current phase (maze_pkg encoding)
//   map_visible  : high in SHOW_MAP, LOST, WON
//   move_done    : pulse when a move commits
//   hit          : pulse when a wall is hit
//   lost, won    : end-of-game flags
module maze_game_ctrl
    import maze_pkg::*;
#(
    parameter int MAP_W         = 30,
    parameter int MAP_H         = 21,
    parameter int START_X       = 0,
    parameter int START_Y       = 10,
    parameter int GOAL_X        = 29,
    parameter int GOAL_Y        = 11,
    parameter int SHOW_EASY     = 300000000,
    parameter int SHOW_MED      = 150000000,
    parameter int SHOW_HARD     = 50000000,
    parameter int MOVE_COOLDOWN = 5000000,
    parameter int LIVES         = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [1:0]               diff_sel,
    input  logic [3:0]               move_req,
    output logic [$clog2(MAP_H)-1:0] rom_addr,
    input  logic [MAP_W-1:0]         rom_data,
    output logic [7:0]               player_x,
    output logic [7:0]               player_y,
    output logic [3:0]               lives_left,
    output logic [2:0]               phase,
    output logic                     map_visible,
    output logic                     move_done,
    output logic                     hit,
    output logic                     lost,
    output logic                     won
);

    localparam int               AW           = $clog2(MAP_H);
    localparam logic [7:0]       MAX_X        = 8'(MAP_W - 1);
    localparam logic [7:0]       MAX_Y        = 8'(MAP_H - 1);
    localparam logic [7:0]       START_X8     = 8'(START_X);
    localparam logic [7:0]       START_Y8     = 8'(START_Y);
    localparam logic [7:0]       GOAL_X8      = 8'(GOAL_X);
    localparam logic [7:0]       GOAL_Y8      = 8'(GOAL_Y);
    localparam logic [3:0]       LIVES4       = 4'(LIVES);
    localparam logic [31:0]      SHOW_EASY_M1 = 32'(SHOW_EASY - 1);
    localparam logic [31:0]      SHOW_MED_M1  = 32'(SHOW_MED - 1);
    localparam logic [31:0]      SHOW_HARD_M1 = 32'(SHOW_HARD - 1);
    localparam logic [31:0]      COOL_M1      = 32'(MOVE_COOLDOWN - 1);
    localparam logic [MAP_W-1:0] COL0_MASK    = MAP_W'(1);

    logic [2:0]    state_q, state_d;
    logic [7:0]    px_q, px_d, py_q, py_d;
    logic [3:0]    lives_q, lives_d;
    logic [31:0]   timer_q, timer_d;
    logic [7:0]    cand_x_q, cand_x_d, cand_y_q, cand_y_d;
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic          move_done_q, move_done_d;
    logic          hit_q, hit_d;
    logic          vis_q, vis_d;
    logic          lost_q, lost_d;
    logic          won_q, won_d;

    logic          cd_load;
    logic          cd_zero;
    logic [7:0]    step_x, step_y;
    logic          wall;

    move_cooldown #(
        .W (32)
    ) u_cooldown (
        .clk      (clk),
        .reset    (reset),
        .load     (cd_load),
        .load_val (COOL_M1),
        .zero     (cd_zero)
    );

    // Requested neighbour tile. Only the highest-priority pulse counts, and a
    // step off the map edge leaves the position unchanged, which the FSM uses
    // to recognise "nothing to do".
    always_comb begin
        step_x = px_q;
        step_y = py_q;
        if (move_req[DIR_UP]) begin
            step_y = sat_step(py_q, 1'b0, MAX_Y);
        end else if (move_req[DIR_DOWN]) begin
            step_y = sat_step(py_q, 1'b1, MAX_Y);
        end else if (move_req[DIR_LEFT]) begin
            step_x = sat_step(px_q, 1'b0, MAX_X);
        end else if (move_req[DIR_RIGHT]) begin
            step_x = sat_step(px_q, 1'b1, MAX_X);
        end
    end

    // Column select on the row returned by the ROM for the latched candidate
    assign wall = |(rom_data & (COL0_MASK << cand_x_q));

    // Phase sequencing, position/lives bookkeeping and output flags
    always_comb begin
        state_d     = state_q;
        px_d        = px_q;
        py_d        = py_q;
        lives_d     = lives_q;
        timer_d     = timer_q;
        cand_x_d    = cand_x_q;
        cand_y_d    = cand_y_q;
        rom_addr_d  = rom_addr_q;
        move_done_d = 1'b0;
        hit_d       = 1'b0;
        cd_load     = 1'b0;

        case (state_q)
            ST_MENU: begin
                if (start) begin
                    if (diff_sel == DIFF_EASY) begin
                        timer_d = SHOW_EASY_M1;
                    end else if (diff_sel == DIFF_MED) begin
                        timer_d = SHOW_MED_M1;
                    end else begin
                        timer_d = SHOW_HARD_M1;
                    end
                    px_d    = START_X8;
                    py_d    = START_Y8;
                    lives_d = LIVES4;
                    state_d = ST_SHOW_MAP;
                end
            end
            ST_SHOW_MAP: begin
                if (timer_q == 32'd0) begin
                    state_d = ST_PLAYING;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            ST_PLAYING: begin
                if (cd_zero && ((step_x != px_q) || (step_y != py_q))) begin
                    cand_x_d   = step_x;
                    cand_y_d   = step_y;
                    rom_addr_d = step_y[AW-1:0];
                    state_d    = ST_CHECK;
                end
            end
            ST_CHECK: begin
                cd_load = 1'b1;
                if (wall) begin
                    px_d    = START_X8;
                    py_d    = START_Y8;
                    lives_d = lives_q - 4'd1;
                    hit_d   = 1'b1;
                    state_d = (lives_q <= 4'd1) ? ST_LOST : ST_PLAYING;
                end else begin
                    px_d        = cand_x_q;
                    py_d        = cand_y_q;
                    move_done_d = 1'b1;
                    state_d     = ((cand_x_q == GOAL_X8) && (cand_y_q == GOAL_Y8))
                                  ? ST_WON : ST_PLAYING;
                end
            end
            ST_LOST, ST_WON: begin
                if (start) begin
                    state_d = ST_MENU;
                end
            end
            default: begin
                state_d = ST_MENU;
            end
        endcase

        vis_d  = (state_d == ST_SHOW_MAP) || (state_d == ST_LOST) || (state_d == ST_WON);
        lost_d = (state_d == ST_LOST);
        won_d  = (state_d == ST_WON);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_MENU;
            px_q        <= START_X8;
            py_q        <= START_Y8;
            lives_q     <= LIVES4;
            timer_q     <= 32'd0;
            cand_x_q    <= 8'd0;
            cand_y_q    <= 8'd0;
            rom_addr_q  <= '0;
            move_done_q <= 1'b0;
            hit_q       <= 1'b0;
            vis_q       <= 1'b0;
            lost_q      <= 1'b0;
            won_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            px_q        <= px_d;
            py_q        <= py_d;
            lives_q     <= lives_d;
            timer_q     <= timer_d;
            cand_x_q    <= cand_x_d;
            cand_y_q    <= cand_y_d;
            rom_addr_q  <= rom_addr_d;
            move_done_q <= move_done_d;
            hit_q       <= hit_d;
            vis_q       <= vis_d;
            lost_q      <= lost_d;
            won_q       <= won_d;
        end
    end

    // The address is presented one cycle ahead of its register so the ROM
    // captures the candidate row on the edge entering CHECK; the row is then
    // on rom_data throughout the single CHECK cycle.
    assign rom_addr    = reset ? '0 : rom_addr_d;
    assign player_x    = px_q;
    assign player_y    = py_q;
    assign lives_left  = lives_q;
    assign phase       = state_q;
    assign map_visible = vis_q;
    assign move_done   = move_done_q;
    assign hit         = hit_q;
    assign lost        = lost_q;
    assign won         = won_q;

endmodule

// File: tb/tb_maze_game_ctrl.sv
// tb_maze_game_ctrl
// Directed bench for maze_game_ctrl on a 30x21 map with a single wall at (1,10).
// Every expected move/hit commit is queued when the request is issued; the
// monitor pops one entry per move_done/hit pulse and compares position, lives
// and phase. Phase-level expectations are compared inline.
`timescale 1ns/1ps
module tb_maze_game_ctrl;
    import maze_pkg::*;

    localparam int MAP_W = 30;
    localparam int MAP_H = 21;
    localparam int AW    = $clog2(MAP_H);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       diff_sel = 2'b00;
    logic [3:0]       move_req = 4'b0000;
    logic [AW-1:0]    rom_addr;
    logic [MAP_W-1:0] rom_data;
    logic [7:0]       player_x;
    logic [7:0]       player_y;
    logic [3:0]       lives_left;
    logic [2:0]       phase;
    logic             map_visible;
    logic             move_done;
    logic             hit;
    logic             lost;
    logic             won;

    logic [MAP_W-1:0] map_rows [0:MAP_H-1];

    typedef struct packed {
        logic       is_hit;
        logic [7:0] x;
        logic [7:0] y;
        logic [3:0] lives;
        logic [2:0] ph;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    maze_game_ctrl #(
        .MAP_W         (MAP_W),
        .MAP_H         (MAP_H),
        .START_X       (0),
        .START_Y       (10),
        .GOAL_X        (29),
        .GOAL_Y        (11),
        .SHOW_EASY     (8),
        .SHOW_MED      (4),
        .SHOW_HARD     (2),
        .MOVE_COOLDOWN (3),
        .LIVES         (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .diff_sel    (diff_sel),
        .move_req    (move_req),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .player_x    (player_x),
        .player_y    (player_y),
        .lives_left  (lives_left),
        .phase       (phase),
        .map_visible (map_visible),
        .move_done   (move_done),
        .hit         (hit),
        .lost        (lost),
        .won         (won)
    );

    always #5 clk = ~clk;

    // Open map with one wall tile at column 1 of row 10
    initial begin
        for (int r = 0; r < MAP_H; r++) begin
            map_rows[r] = '0;
        end
        map_rows[10][1] = 1'b1;
    end

    // Synchronous map ROM: row appears one cycle after the address
    always @(posedge clk) begin
        rom_data <= map_rows[rom_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds the inputs across exactly one sampling edge, returns 1ns after it
    task automatic applyStimulus(input logic s, input logic [1:0] d, input logic [3:0] m);
        start    = s;
        diff_sel = d;
        move_req = m;
        @(posedge clk);
        #1;
        start    = 1'b0;
        move_req = 4'b0000;
    endtask

    task automatic expect_event(input logic is_hit, input logic [7:0] x, input logic [7:0] y,
                                input logic [3:0] lv, input logic [2:0] ph);
        exp_t e;
        e.is_hit = is_hit;
        e.x      = x;
        e.y      = y;
        e.lives  = lv;
        e.ph     = ph;
        sb_q.push_back(e);
    endtask

    // Issue a move, let it commit, and wait out the cooldown
    task automatic do_move(input logic [3:0] m, input logic is_hit, input logic [7:0] x,
                           input logic [7:0] y, input logic [3:0] lv, input logic [2:0] ph);
        expect_event(is_hit, x, y, lv, ph);
        applyStimulus(1'b0, 2'b00, m);
        wait_cycles(3);
    endtask

    // Scoreboard monitor: one queue entry per committed move or wall hit
    always @(negedge clk) begin : monitor
        exp_t e;
        if (move_done || hit) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_pulse", 32'({hit, move_done}), 32'd0);
            end else begin
                e = sb_q.pop_front();
                checkOutput("ev_kind", 32'({hit, move_done}), e.is_hit ? 32'd2 : 32'd1);
                checkOutput("ev_x", 32'(player_x), 32'(e.x));
                checkOutput("ev_y", 32'(player_y), 32'(e.y));
                checkOutput("ev_lives", 32'(lives_left), 32'(e.lives));
                checkOutput("ev_phase", 32'(phase), 32'(e.ph));
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        checkOutput("rst_phase", 32'(phase), 32'(ST_MENU));
        checkOutput("rst_x", 32'(player_x), 32'd0);
        checkOutput("rst_y", 32'(player_y), 32'd10);
        checkOutput("rst_lives", 32'(lives_left), 32'd2);
        checkOutput("rst_rom_addr", 32'(rom_addr), 32'd0);
        checkOutput("rst_flags", 32'({map_visible, lost, won, move_done, hit}), 32'd0);

        // Medium reveal lasts four cycles
        applyStimulus(1'b1, DIFF_MED, 4'b0000);
        checkOutput("med_show_c1", 32'(phase), 32'(ST_SHOW_MAP));
        checkOutput("med_visible", 32'(map_visible), 32'd1);
        wait_cycles(3);
        checkOutput("med_show_c4", 32'(phase), 32'(ST_SHOW_MAP));
        wait_cycles(1);
        checkOutput("med_playing", 32'(phase), 32'(ST_PLAYING));
        checkOutput("med_visible_drop", 32'(map_visible), 32'd0);

        // Up commits two edges after the request
        expect_event(1'b0, 8'd0, 8'd9, 4'd2, ST_PLAYING);
        applyStimulus(1'b0, 2'b00, 4'b0001);
        checkOutput("up_in_check", 32'(phase), 32'(ST_CHECK));
        wait_cycles(1);
        checkOutput("up_y", 32'(player_y), 32'd9);

        // Down one cycle after commit is dropped by the cooldown
        applyStimulus(1'b0, 2'b00, 4'b0010);
        checkOutput("drop_phase", 32'(phase), 32'(ST_PLAYING));
        checkOutput("drop_y", 32'(player_y), 32'd9);

        // Down three cycles after commit is accepted
        wait_cycles(1);
        do_move(4'b0010, 1'b0, 8'd0, 8'd10, 4'd2, ST_PLAYING);

        // Left at column 0 saturates: nothing happens, no cooldown started
        applyStimulus(1'b0, 2'b00, 4'b0100);
        checkOutput("sat_phase", 32'(phase), 32'(ST_PLAYING));
        checkOutput("sat_x", 32'(player_x), 32'd0);
        checkOutput("sat_rom_addr", 32'(rom_addr), 32'd10);

        // Right into the wall straight away, then a second hit from above
        do_move(4'b1000, 1'b1, 8'd0, 8'd10, 4'd1, ST_PLAYING);
        do_move(4'b0001, 1'b0, 8'd0, 8'd9, 4'd1, ST_PLAYING);
        do_move(4'b1000, 1'b0, 8'd1, 8'd9, 4'd1, ST_PLAYING);
        do_move(4'b0010, 1'b1, 8'd0, 8'd10, 4'd0, ST_LOST);
        checkOutput("lost_flag", 32'(lost), 32'd1);
        checkOutput("lost_visible", 32'(map_visible), 32'd1);

        // Moves are ignored once lost; start returns to the menu
        applyStimulus(1'b0, 2'b00, 4'b0001);
        checkOutput("lost_hold_y", 32'(player_y), 32'd10);
        applyStimulus(1'b1, 2'b00, 4'b0000);
        checkOutput("lost_to_menu", 32'(phase), 32'(ST_MENU));
        checkOutput("menu_lost_clear", 32'(lost), 32'd0);

        // Hard reveal lasts two cycles and restores lives
        applyStimulus(1'b1, DIFF_HARD, 4'b0000);
        checkOutput("hard_lives", 32'(lives_left), 32'd2);
        wait_cycles(1);
        checkOutput("hard_show_c2", 32'(phase), 32'(ST_SHOW_MAP));
        wait_cycles(1);
        checkOutput("hard_playing", 32'(phase), 32'(ST_PLAYING));

        // Up+right together: only up applies
        do_move(4'b1001, 1'b0, 8'd0, 8'd9, 4'd2, ST_PLAYING);
        do_move(4'b0010, 1'b0, 8'd0, 8'd10, 4'd2, ST_PLAYING);
        do_move(4'b0010, 1'b0, 8'd0, 8'd11, 4'd2, ST_PLAYING);

        // Walk row 11 to the goal
        for (int i = 1; i < 29; i++) begin
            do_move(4'b1000, 1'b0, 8'(i), 8'd11, 4'd2, ST_PLAYING);
        end
        do_move(4'b1000, 1'b0, 8'd29, 8'd11, 4'd2, ST_WON);
        checkOutput("won_flag", 32'(won), 32'd1);
        checkOutput("won_x", 32'(player_x), 32'd29);
        checkOutput("won_y", 32'(player_y), 32'd11);
        applyStimulus(1'b1, 2'b00, 4'b0000);
        checkOutput("won_to_menu", 32'(phase), 32'(ST_MENU));

        // diff_sel 11 behaves as hard; reset lands while the wall check is pending
        applyStimulus(1'b1, 2'b11, 4'b0000);
        wait_cycles(2);
        checkOutput("diff11_playing", 32'(phase), 32'(ST_PLAYING));
        applyStimulus(1'b0, 2'b00, 4'b1000);
        checkOutput("pre_reset_check", 32'(phase), 32'(ST_CHECK));
        reset = 1'b1;
        wait_cycles(1);
        checkOutput("rc_phase", 32'(phase), 32'(ST_MENU));
        checkOutput("rc_x", 32'(player_x), 32'd0);
        checkOutput("rc_y", 32'(player_y), 32'd10);
        checkOutput("rc_lives", 32'(lives_left), 32'd2);
        checkOutput("rc_pulses", 32'({hit, move_done}), 32'd0);
        checkOutput("rc_rom_addr", 32'(rom_addr), 32'd0);
        reset = 1'b0;

        wait_cycles(4);
        checkOutput("scoreboard_drain", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
